// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB configuration sequencer: FSM state codes,
// ROM marker values and the layout of one 40-bit ROM entry.
package sccb_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_PWR_WAIT = 4'd1;
    localparam state_t S_FETCH    = 4'd2;
    localparam state_t S_DECODE   = 4'd3;
    localparam state_t S_DELAY    = 4'd4;
    localparam state_t S_XFER     = 4'd5;
    localparam state_t S_GAP      = 4'd6;
    localparam state_t S_DONE     = 4'd7;
    localparam state_t S_ERROR    = 4'd8;
    localparam state_t S_RD_XFER  = 4'd9;
    localparam state_t S_RD_GAP   = 4'd10;

    localparam logic [7:0]  END_ID  = 8'hFF;
    localparam logic [15:0] END_SUB = 16'hFFFF;
    localparam logic [7:0]  DLY_ID  = 8'hFE;

    localparam int RID_MSB = 39;
    localparam int RID_LSB = 32;
    localparam int WID_MSB = 31;
    localparam int WID_LSB = 24;
    localparam int SUB_MSB = 23;
    localparam int SUB_LSB = 8;
    localparam int DAT_MSB = 7;
    localparam int DAT_LSB = 0;

    typedef struct packed {
        logic [7:0]  rd_id;
        logic [7:0]  wr_id;
        logic [15:0] sub;
        logic [7:0]  data;
    } lut_entry_t;

    function automatic logic is_end_marker(input lut_entry_t e);
        return (e.wr_id == END_ID) && (e.sub == END_SUB);
    endfunction

endpackage

// File: rtl/sccb_config_sequencer_clk_gen.sv
// Free-running SCL divider. i2c_clk is low for the first CLK_DIV/2 counts and
// high for the rest; i2c_en pulses once per period in the middle of the low half.
module sccb_clk_gen
    import sccb_pkg::*;
#(
    parameter int CLK_DIV = 400
) (
    input  logic clk,
    input  logic rst_n,
    output logic i2c_clk,
    output logic i2c_en
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_cnt_nxt;

    // wrap the divider count at the end of each SCL period
    always_comb begin
        div_cnt_nxt = (div_cnt == CW'(CLK_DIV - 1)) ? '0 : div_cnt + CW'(1);
    end

    // register the count and decode SCL level and enable tick from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            i2c_clk <= 1'b1;
            i2c_en  <= 1'b0;
        end else begin
            div_cnt <= div_cnt_nxt;
            i2c_clk <= (div_cnt_nxt >= CW'(CLK_DIV / 2));
            i2c_en  <= (div_cnt_nxt == CW'(CLK_DIV / 4));
        end
    end

endmodule

// File: rtl/sccb_config_sequencer.sv
// SCCB configuration sequencer: walks a synchronous init ROM and drives the
// byte-transfer controller, with retry on NACK and delay/end marker handling.
// Optional macro SCCB_READBACK_EN adds a read-back verify of every written entry.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a start rising edge
// PWR_WAIT | power-up settle time before the first entry
// FETCH    | lut_index presented, ROM read in flight
// DECODE   | latch entry on an i2c_en tick and dispatch on its markers
// DELAY    | millisecond wait requested by a delay marker
// XFER     | write transfer requested, waiting for i2c_end
// GAP      | trans low, letting the controller settle before the next step
// RD_XFER  | read-back transfer of the same entry (readback build only)
// RD_GAP   | settle after read-back (readback build only)
// DONE     | sequence completed, sticky done
// ERROR    | retries exhausted, sticky error
module sccb_config_sequencer
    import sccb_pkg::*;
#(
    parameter int CLK_DIV   = 400,
    parameter int LUT_DEPTH = 256,
    parameter int RETRY_MAX = 3,
    parameter int PWRUP_MS  = 20,
    parameter int MS_TICKS  = 27000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic [$clog2(LUT_DEPTH)-1:0] lut_index,
    input  logic [39:0]                  lut_data,
    output logic                         i2c_en,
    output logic                         i2c_clk,
    output logic [39:0]                  i2c_wdata,
    output logic                         wr,
    output logic                         trans,
    input  logic                         i2c_end,
    input  logic                         ack,
    input  logic [7:0]                   i2c_rdata,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(LUT_DEPTH)-1:0] err_index
);

    localparam int IW = $clog2(LUT_DEPTH);
    localparam int TW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam int MW = 16;

    state_t     state;
    logic       start_q;
    logic [TW-1:0] tick_cnt;
    logic [MW-1:0] ms_left;
    logic [RW-1:0] retry_cnt;
    logic       armed;
    logic       gap_seen;
    logic       nack_q;
    lut_entry_t ent_in;

    logic start_rise;
    logic ms_done;
    logic end_ok;
    logic gap_ok;
    logic at_last;
    logic retry_full;
    logic unused_bits;

    sccb_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i2c_clk (i2c_clk),
        .i2c_en  (i2c_en)
    );

    assign ent_in      = lut_data;
    assign start_rise  = start & ~start_q;
    assign ms_done     = (ms_left == '0) || ((ms_left == MW'(1)) && (tick_cnt == '0));
    // a stale i2c_end is ignored until trans has seen at least one tick
    assign end_ok      = i2c_en && armed && i2c_end;
    assign gap_ok      = i2c_en && gap_seen && !i2c_end;
    assign at_last     = (lut_index == IW'(LUT_DEPTH - 1));
    assign retry_full  = (retry_cnt == RW'(RETRY_MAX));

    assign trans = (state == S_XFER) || (state == S_RD_XFER);
    assign busy  = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

`ifdef SCCB_READBACK_EN
    logic wr_q;
    logic rd_fail;
    assign wr          = wr_q;
    assign rd_fail     = ack || (i2c_rdata != i2c_wdata[DAT_MSB:DAT_LSB]);
    assign unused_bits = ^ent_in.rd_id;
`else
    assign wr          = 1'b1;
    assign unused_bits = ^{ent_in.rd_id, i2c_rdata};
`endif

    // start edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    // sequencing FSM with inline millisecond timer and retry bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lut_index <= '0;
            i2c_wdata <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            tick_cnt  <= '0;
            ms_left   <= '0;
            retry_cnt <= '0;
            armed     <= 1'b0;
            gap_seen  <= 1'b0;
            nack_q    <= 1'b0;
`ifdef SCCB_READBACK_EN
            wr_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_rise) begin
                        done      <= 1'b0;
                        error     <= 1'b0;
                        lut_index <= '0;
                        retry_cnt <= '0;
                        ms_left   <= MW'(PWRUP_MS);
                        tick_cnt  <= TW'(MS_TICKS - 1);
                        state     <= S_PWR_WAIT;
                    end
                end

                S_PWR_WAIT, S_DELAY: begin
                    if (ms_done) begin
                        if (state == S_PWR_WAIT) begin
                            state <= S_FETCH;
                        end else if (at_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            lut_index <= lut_index + IW'(1);
                            retry_cnt <= '0;
                            state     <= S_FETCH;
                        end
                    end else if (tick_cnt == '0) begin
                        tick_cnt <= TW'(MS_TICKS - 1);
                        ms_left  <= ms_left - MW'(1);
                    end else begin
                        tick_cnt <= tick_cnt - TW'(1);
                    end
                end

                S_FETCH: begin
                    state <= S_DECODE;
                end

                // dispatch waits for a tick so every output change follows i2c_en
                S_DECODE: begin
                    if (i2c_en) begin
                        i2c_wdata <= lut_data;
                        if (is_end_marker(ent_in)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (ent_in.wr_id == DLY_ID) begin
                            ms_left  <= MW'(ent_in.data);
                            tick_cnt <= TW'(MS_TICKS - 1);
                            state    <= S_DELAY;
                        end else begin
                            armed <= 1'b0;
`ifdef SCCB_READBACK_EN
                            wr_q  <= 1'b1;
`endif
                            state <= S_XFER;
                        end
                    end
                end

                S_XFER: begin
                    if (i2c_en) begin
                        armed <= 1'b1;
                    end
                    if (end_ok) begin
                        nack_q   <= ack;
                        gap_seen <= 1'b0;
                        state    <= S_GAP;
                    end
                end

                S_GAP, S_RD_GAP: begin
                    if (gap_ok) begin
                        if (nack_q) begin
                            if (retry_full) begin
                                error     <= 1'b1;
                                err_index <= lut_index;
                                state     <= S_ERROR;
                            end else begin
                                retry_cnt <= retry_cnt + RW'(1);
                                armed     <= 1'b0;
`ifdef SCCB_READBACK_EN
                                wr_q      <= 1'b1;
`endif
                                state     <= S_XFER;
                            end
`ifdef SCCB_READBACK_EN
                        end else if (state == S_GAP) begin
                            armed <= 1'b0;
                            wr_q  <= 1'b0;
                            state <= S_RD_XFER;
`endif
                        end else if (at_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            lut_index <= lut_index + IW'(1);
                            retry_cnt <= '0;
                            state     <= S_FETCH;
                        end
                    end else if (i2c_en) begin
                        gap_seen <= 1'b1;
                    end
                end

`ifdef SCCB_READBACK_EN
                S_RD_XFER: begin
                    if (i2c_en) begin
                        armed <= 1'b1;
                    end
                    if (end_ok) begin
                        nack_q   <= rd_fail;
                        gap_seen <= 1'b0;
                        state    <= S_RD_GAP;
                    end
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
